// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter FSM encoding, common keyboard
// commands and the cycle-count derivations used by the host transmitter.
package ps2_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_SEND,
    S_ACK,
    S_WAITIDLE,
    S_DONE,
    S_ERR
  } ps2_state_t;

  localparam logic [7:0] CMD_SETLEDS = 8'hED;
  localparam logic [7:0] CMD_RESET   = 8'hFF;
  localparam logic [7:0] CMD_ECHO    = 8'hEE;

  // Clock cycles the host holds the clock line low before request-to-send.
  function automatic int inh_cycles(input int clkfreq_khz, input int inhibit_us);
    return clkfreq_khz * inhibit_us / 1000;
  endfunction

  // Clock cycles allowed from clock release to the end of the frame.
  function automatic int to_cycles(input int clkfreq_khz, input int timeout_ms);
    return clkfreq_khz * timeout_ms;
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizer for one raw PS/2 pad plus a falling-edge detector
// on the synchronized level. Shared by the host transmitter and receiver.
module ps2_line_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic fall
);

  logic sync_p0;
  logic sync_p1;
  logic prev_p2;

  // Synchronize the pad and keep one extra sample for edge detection; idle lines read high.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_p0 <= 1'b1;
      sync_p1 <= 1'b1;
      prev_p2 <= 1'b1;
    end else begin
      sync_p0 <= din;
      sync_p1 <= sync_p0;
      prev_p2 <= sync_p1;
    end
  end

  assign level = sync_p1;
  assign fall  = prev_p2 & ~sync_p1;

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter. Inhibits the bus, issues request-to-send,
// shifts {stop, odd parity, byte} out LSB first on device clock falls and
// checks the device ACK. rx_inhibit tells the neighbouring receiver to drop
// line activity while a transmit is in progress.
// Optional build macro PS2TX_AUTO_RETRY_EN: the first failure of a request
// silently re-enters INHIBIT with the same byte; only a second failure
// pulses tx_error.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int CLKFREQ_KHZ = 6000,
  parameter int INHIBIT_US  = 120,
  parameter int TIMEOUT_MS  = 15
) (
  input  logic       clk6,
  input  logic       master_reset_n,
  input  logic       ps2clk_in,
  input  logic       ps2data_in,
  output logic       ps2clk_oe,
  output logic       ps2data_oe,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_error,
  output logic       rx_inhibit
);

  localparam int INH_CYC = inh_cycles(CLKFREQ_KHZ, INHIBIT_US);
  localparam int TO_CYC  = to_cycles(CLKFREQ_KHZ, TIMEOUT_MS);
  localparam int CNT_W   = $clog2(TO_CYC + 1);
  localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INH_CYC - 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TO_CYC - 1);

  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

  ps2_state_t       state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [3:0]       bitcnt, bitcnt_n;
  logic             clk_oe, clk_oe_n;
  logic             data_oe, data_oe_n;
  logic [7:0]       data_q;
  logic [9:0]       shreg;
  logic             load_byte, load_frame, shift, fail, timed;
  logic             clk_level, clk_fall, data_level, unused_data_fall;
`ifdef PS2TX_AUTO_RETRY_EN
  logic             retry, retry_n;
`endif

  ps2_line_sync u_clk_sync (
    .clk   (clk6),
    .rst_n (master_reset_n),
    .din   (ps2clk_in),
    .level (clk_level),
    .fall  (clk_fall)
  );

  ps2_line_sync u_data_sync (
    .clk   (clk6),
    .rst_n (master_reset_n),
    .din   (ps2data_in),
    .level (data_level),
    .fall  (unused_data_fall)
  );

  // Control state: FSM, shared cycle counter, edge counter and line drivers.
  always_ff @(posedge clk6) begin
    if (!master_reset_n) begin
      state   <= S_IDLE;
      cnt     <= '0;
      bitcnt  <= '0;
      clk_oe  <= 1'b0;
      data_oe <= 1'b0;
`ifdef PS2TX_AUTO_RETRY_EN
      retry   <= 1'b0;
`endif
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      bitcnt  <= bitcnt_n;
      clk_oe  <= clk_oe_n;
      data_oe <= data_oe_n;
`ifdef PS2TX_AUTO_RETRY_EN
      retry   <= retry_n;
`endif
    end
  end

  // Datapath: latched byte and the frame shift register (no reset needed).
  always_ff @(posedge clk6) begin
    if (load_byte) data_q <= tx_data;
    if (load_frame) shreg <= {1'b1, odd_parity(data_q), data_q};
    else if (shift) shreg <= shreg >> 1;
  end

  // Next-state, counters and line drive decisions.
  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    bitcnt_n   = bitcnt;
    clk_oe_n   = clk_oe;
    data_oe_n  = data_oe;
    load_byte  = 1'b0;
    load_frame = 1'b0;
    shift      = 1'b0;
    fail       = 1'b0;
`ifdef PS2TX_AUTO_RETRY_EN
    retry_n    = retry;
`endif
    timed = (state == S_SEND) || (state == S_ACK) || (state == S_WAITIDLE);

    case (state)
      S_IDLE, S_DONE, S_ERR: begin
        state_n   = S_IDLE;
        clk_oe_n  = 1'b0;
        data_oe_n = 1'b0;
        if (tx_start) begin
          state_n   = S_INHIBIT;
          clk_oe_n  = 1'b1;
          cnt_n     = '0;
          load_byte = 1'b1;
`ifdef PS2TX_AUTO_RETRY_EN
          retry_n   = 1'b0;
`endif
        end
      end
      S_INHIBIT: begin
        // Device activity is ignored here: the host keeps the clock low regardless.
        clk_oe_n  = 1'b1;
        data_oe_n = 1'b0;
        cnt_n     = cnt + CNT_W'(1);
        if (cnt == INH_LAST) begin
          state_n    = S_SEND;
          clk_oe_n   = 1'b0;
          data_oe_n  = 1'b1;
          cnt_n      = '0;
          bitcnt_n   = '0;
          load_frame = 1'b1;
        end
      end
      S_SEND: begin
        cnt_n = cnt + CNT_W'(1);
        if (clk_fall) begin
          bitcnt_n  = bitcnt + 4'd1;
          data_oe_n = ~shreg[0];
          shift     = 1'b1;
          if (bitcnt == 4'd9) state_n = S_ACK;
        end
      end
      S_ACK: begin
        cnt_n = cnt + CNT_W'(1);
        if (clk_fall) begin
          bitcnt_n = bitcnt + 4'd1;
          if (data_level) fail = 1'b1;
          else state_n = S_WAITIDLE;
        end
      end
      S_WAITIDLE: begin
        cnt_n = cnt + CNT_W'(1);
        if (clk_level && data_level) state_n = S_DONE;
      end
      default: begin
        state_n   = S_IDLE;
        clk_oe_n  = 1'b0;
        data_oe_n = 1'b0;
      end
    endcase

    if (timed && (cnt == TO_LAST)) fail = 1'b1;

    if (fail) begin
      clk_oe_n  = 1'b0;
      data_oe_n = 1'b0;
      state_n   = S_ERR;
`ifdef PS2TX_AUTO_RETRY_EN
      if (!retry) begin
        state_n  = S_INHIBIT;
        clk_oe_n = 1'b1;
        cnt_n    = '0;
        retry_n  = 1'b1;
      end
`endif
    end
  end

  assign ps2clk_oe  = clk_oe;
  assign ps2data_oe = data_oe;
  assign tx_busy    = (state == S_INHIBIT) || (state == S_SEND) ||
                      (state == S_ACK) || (state == S_WAITIDLE);
  assign rx_inhibit = tx_busy;
  assign tx_done    = (state == S_DONE);
  assign tx_error   = (state == S_ERR);

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx: a keyboard model clocks frames in, samples
// bits on its rising clock edges and ACKs or NACKs. Follows the
// PS2TX_AUTO_RETRY_EN macro when it is defined for the build.
module tb_ps2_host_tx;

  // 6 MHz default clock; 120 us inhibit -> 720 cycles; 2 ms timeout -> 12000 cycles.
  localparam int INH_EXP = 720;
  localparam int TO_EXP  = 12000;

  logic       clk = 1'b0;
  logic       master_reset_n = 1'b0;
  logic       ps2clk_oe, ps2data_oe;
  logic [7:0] tx_data = 8'h00;
  logic       tx_start = 1'b0;
  logic       tx_busy, tx_done, tx_error, rx_inhibit;
  logic       dev_clk_low = 1'b0;
  logic       dev_data_low = 1'b0;
  logic       clk_line, data_line;

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int inhibit_bad = 0;
  logic watch = 1'b0;

  assign clk_line  = ~(ps2clk_oe | dev_clk_low);
  assign data_line = ~(ps2data_oe | dev_data_low);

  ps2_host_tx #(.TIMEOUT_MS(2)) dut (
    .clk6           (clk),
    .master_reset_n (master_reset_n),
    .ps2clk_in      (clk_line),
    .ps2data_in     (data_line),
    .ps2clk_oe      (ps2clk_oe),
    .ps2data_oe     (ps2data_oe),
    .tx_data        (tx_data),
    .tx_start       (tx_start),
    .tx_busy        (tx_busy),
    .tx_done        (tx_done),
    .tx_error       (tx_error),
    .rx_inhibit     (rx_inhibit)
  );

  always #5 clk = ~clk;

  // Pulse counters and rx_inhibit watch, sampled on the inactive edge.
  always @(negedge clk) begin
    if (tx_done === 1'b1) done_cnt <= done_cnt + 1;
    if (tx_error === 1'b1) err_cnt <= err_cnt + 1;
    if (watch && rx_inhibit !== 1'b1) inhibit_bad <= inhibit_bad + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start_tx(input logic [7:0] b);
    @(negedge clk);
    tx_data  = b;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
  endtask

  // Keyboard model: waits for request-to-send, generates nclk clocks and
  // samples the data line just before each rising edge; with nclk = 10 it
  // adds the 11th clock, holding data low for an ACK when ack = 1.
  task automatic dev_frame(input int half, input int nclk, input bit ack, output logic [9:0] bits);
    int n;
    bits = '0;
    n = 0;
    while (!(ps2clk_oe === 1'b0 && ps2data_oe === 1'b1) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check("rts", {30'd0, ps2clk_oe, ps2data_oe}, 32'd1);
    check("start_bit", {31'd0, data_line}, 32'd0);
    repeat (half) @(negedge clk);
    for (int i = 0; i < nclk; i++) begin
      dev_clk_low = 1'b1;
      repeat (half) @(negedge clk);
      bits[i] = data_line;
      dev_clk_low = 1'b0;
      repeat (half) @(negedge clk);
    end
    if (nclk == 10) begin
      if (ack) dev_data_low = 1'b1;
      repeat (4) @(negedge clk);
      dev_clk_low = 1'b1;
      repeat (half) @(negedge clk);
      watch = 1'b0;
      dev_clk_low = 1'b0;
      dev_data_low = 1'b0;
      repeat (half) @(negedge clk);
    end
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (tx_busy === 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check(tag, {31'd0, tx_busy}, 32'd0);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    logic [9:0] bits;
    logic [7:0] pbyte [3];
    logic       ppar [3];
    int n, d0, e0;

    pbyte[0] = 8'h00; ppar[0] = 1'b1;
    pbyte[1] = 8'hFF; ppar[1] = 1'b1;
    pbyte[2] = 8'h01; ppar[2] = 1'b0;

    // Reset state
    repeat (4) @(negedge clk);
    check("reset_outs", {26'd0, ps2clk_oe, ps2data_oe, tx_busy, tx_done, tx_error, rx_inhibit}, 32'd0);
    master_reset_n = 1'b1;
    repeat (5) @(negedge clk);

    // 0xED at 12.5 kHz with a second request (0x55) while busy
    d0 = done_cnt; e0 = err_cnt;
    start_tx(8'hED);
    watch = 1'b1;
    n = 0;
    while (ps2clk_oe === 1'b1 && n < 5000) begin
      if (n == 100) begin
        tx_data  = 8'h55;
        tx_start = 1'b1;
      end else begin
        tx_start = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    tx_start = 1'b0;
    check("inhibit_len", n, INH_EXP);
    dev_frame(240, 10, 1'b1, bits);
    check("ed_byte", {24'd0, bits[7:0]}, 32'hED);
    check("ed_parity", {31'd0, bits[8]}, 32'd1);
    check("ed_stop", {31'd0, bits[9]}, 32'd1);
    wait_idle("ed_idle");
    check("ed_done", done_cnt - d0, 32'd1);
    check("ed_noerr", err_cnt - e0, 32'd0);
    check("ed_rx_inhibit", inhibit_bad, 32'd0);

    // Parity boundaries
    for (int i = 0; i < 3; i++) begin
      d0 = done_cnt;
      start_tx(pbyte[i]);
      dev_frame(60, 10, 1'b1, bits);
      check($sformatf("par%0d_byte", i), {24'd0, bits[7:0]}, {24'd0, pbyte[i]});
      check($sformatf("par%0d_parity", i), {31'd0, bits[8]}, {31'd0, ppar[i]});
      check($sformatf("par%0d_stop", i), {31'd0, bits[9]}, 32'd1);
      wait_idle($sformatf("par%0d_idle", i));
      check($sformatf("par%0d_done", i), done_cnt - d0, 32'd1);
    end

    // Timeout: device never clocks
    d0 = done_cnt; e0 = err_cnt;
    start_tx(8'hA5);
    n = 0;
    while (ps2clk_oe === 1'b1 && n < 5000) begin
      @(negedge clk);
      n++;
    end
`ifdef PS2TX_AUTO_RETRY_EN
    repeat (TO_EXP) @(negedge clk);
    check("to_retry_inhibit", {30'd0, ps2clk_oe, tx_error}, 32'd2);
    n = 0;
    while (ps2clk_oe === 1'b1 && n < 5000) begin
      @(negedge clk);
      n++;
    end
`endif
    n = 0;
    while (tx_error !== 1'b1 && n < TO_EXP + 100) begin
      @(negedge clk);
      n++;
    end
    check("timeout_cycles", n, TO_EXP);
    check("timeout_busy", {31'd0, tx_busy}, 32'd0);
    @(negedge clk);
    check("timeout_lines", {30'd0, ps2clk_oe, ps2data_oe}, 32'd0);
    repeat (3) @(negedge clk);
    check("timeout_errcnt", err_cnt - e0, 32'd1);
    check("timeout_nodone", done_cnt - d0, 32'd0);

    // NACK on the 11th clock
    d0 = done_cnt; e0 = err_cnt;
    start_tx(8'hF0);
    dev_frame(60, 10, 1'b0, bits);
    check("nack_byte", {24'd0, bits[7:0]}, 32'hF0);
`ifdef PS2TX_AUTO_RETRY_EN
    dev_frame(60, 10, 1'b1, bits);
    check("retry_byte", {24'd0, bits[7:0]}, 32'hF0);
    wait_idle("nack_idle");
    check("retry_err", err_cnt - e0, 32'd0);
    check("retry_done", done_cnt - d0, 32'd1);
`else
    wait_idle("nack_idle");
    check("nack_err", err_cnt - e0, 32'd1);
    check("nack_nodone", done_cnt - d0, 32'd0);
`endif

    // Reset during bit 4, then a clean 0xFF frame
    d0 = done_cnt; e0 = err_cnt;
    start_tx(8'hED);
    dev_frame(60, 5, 1'b0, bits);
    check("mid_bit4_drive", {30'd0, tx_busy, ps2data_oe}, 32'd3);
    master_reset_n = 1'b0;
    @(negedge clk);
    check("mid_reset_outs", {29'd0, ps2clk_oe, ps2data_oe, tx_busy}, 32'd0);
    master_reset_n = 1'b1;
    repeat (5) @(negedge clk);
    check("mid_reset_pulses", (done_cnt - d0) + (err_cnt - e0), 32'd0);
    d0 = done_cnt;
    start_tx(8'hFF);
    dev_frame(60, 10, 1'b1, bits);
    check("post_reset_byte", {24'd0, bits[7:0]}, 32'hFF);
    check("post_reset_parity", {31'd0, bits[8]}, 32'd1);
    wait_idle("post_reset_idle");
    check("post_reset_done", done_cnt - d0, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
